row_readout_sequencer: RTL and testbench
========================================

# row_readout_sequencer

Upstream feeder of the output buffer. After the sensor state machine finishes a conversion, the sequencer walks the pixel array row by row. For each row it asserts that row's select line, waits for the shared column bus to settle, and latches the row into a holding register. It then hands the row to the output buffer with a SET_BUFFER/BUFFER_BUSY handshake and waits for the buffer to drain before moving to the next row. One pass over all rows is one frame, ended by a single-cycle FRAME_DONE.

## Interface
- PIXEL_ARRAY_WIDTH, from PixelSensorConfig: pixels per row.
- PIXEL_ARRAY_HEIGHT, from PixelSensorConfig: rows per frame, minimum 1.
- PIXEL_BITS, from PixelSensorConfig: bits per pixel.
- SETTLE_CYCLES, 2: cycles the row select is held before capture, minimum 1.
- CLK  in  1  sole clock, rising edge.
- RESET_N  in  1  reset; one clock; reset is synchronous and active-low.
- READ_START  in  1  frame request from the sensor state machine; sampled only in IDLE.
- PIXEL_DATA_IN  in  PIXEL_ARRAY_WIDTH*PIXEL_BITS  shared column bus, driven by the selected row.
- BUFFER_BUSY  in  1  high while the output buffer is draining a row.
- ROW_SELECT  out  PIXEL_ARRAY_HEIGHT  one-hot row enable, all-zero outside SELECT.
- ROW_INDEX  out  max(1,$clog2(PIXEL_ARRAY_HEIGHT))  current row number.
- ROW_DATA  out  PIXEL_ARRAY_WIDTH*PIXEL_BITS  latched row, feeds the output buffer's DATA_IN.
- SET_BUFFER  out  1  row-ready request to the output buffer.
- BUSY  out  1  high whenever state is not IDLE.
- FRAME_DONE  out  1  single-cycle pulse after the last row has drained.

## Operation
- States: IDLE, SELECT, HANDOFF, DRAIN. All outputs are registered.
- **IDLE**
  - READ_START high goes to SELECT with ROW_INDEX=0 and the settle counter at 0.
  - Otherwise stay in IDLE.
- **SELECT**
  - ROW_SELECT = 1<<ROW_INDEX.
  - The settle counter increments each cycle.
  - On the cycle where counter == SETTLE_CYCLES-1: ROW_DATA <= PIXEL_DATA_IN, ROW_SELECT <= 0, SET_BUFFER <= 1, go to HANDOFF.
  - SELECT therefore lasts exactly SETTLE_CYCLES cycles.
- **HANDOFF**
  - SET_BUFFER is held high.
  - When BUFFER_BUSY is sampled high: SET_BUFFER <= 0, go to DRAIN.
- **DRAIN**
  - Wait for BUFFER_BUSY to be sampled low.
  - If ROW_INDEX == PIXEL_ARRAY_HEIGHT-1: go to IDLE, FRAME_DONE <= 1 for one cycle.
  - Otherwise: ROW_INDEX+1, clear the settle counter, go to SELECT.
- ROW_DATA is held unchanged from capture until the next capture. The buffer may sample it at any time while SET_BUFFER or BUFFER_BUSY is high.
- READ_START outside IDLE is ignored, not queued.
- ROW_INDEX does not wrap inside a frame. It returns to 0 only through IDLE → SELECT or reset.
- With PIXEL_ARRAY_HEIGHT=1, the single row is both first and last: FRAME_DONE follows the first drain.

## Timing
- Reset (RESET_N low at a rising edge) puts every output at 0 after that edge: state IDLE, ROW_SELECT=0, ROW_INDEX=0, ROW_DATA=0, SET_BUFFER=0, BUSY=0, FRAME_DONE=0, settle counter 0.
- Reset mid-frame abandons the frame with no FRAME_DONE. It takes priority over every other input.
- READ_START sampled at edge t: BUSY=1 and ROW_SELECT[0]=1 from t+1.
- Capture happens at edge t+SETTLE_CYCLES. SET_BUFFER and the new ROW_DATA are valid from that edge.
- Minimum handoff: BUFFER_BUSY rises one cycle after SET_BUFFER, so SET_BUFFER is high for exactly 2 cycles.
- BUFFER_BUSY already high on entry to HANDOFF (stale from the previous row) counts as acknowledge. The buffer's own new_input gating prevents loss. The bench must not drive this except in the dedicated scenario.
- Row-to-row gap: the edge that samples BUFFER_BUSY low also enters SELECT for the next row, so ROW_SELECT for that row is visible on the following cycle.
- FRAME_DONE is high for the one cycle after the final drain edge, coincident with BUSY=0.
- READ_START sampled in that same cycle starts a new frame immediately (back-to-back frames allowed).

## Test plan
Common configuration: WIDTH=8, HEIGHT=4, PIXEL_BITS=8, SETTLE=2. The buffer model raises BUFFER_BUSY 1 cycle after SET_BUFFER and holds it 4 cycles.

1. **Reset values.** Hold RESET_N low 3 cycles while READ_START=1 and BUFFER_BUSY=1 → every output is 0 and state stays IDLE. After release with READ_START=0, outputs remain 0.
2. **Full frame.** Single READ_START pulse; the bus drives row r as all bytes = 8'hA0+r → ROW_SELECT steps 0001, 0010, 0100, 1000, each high exactly 2 cycles. ROW_DATA is 8'hA0..8'hA3 replicated. There are exactly 4 SET_BUFFER pulses, each 2 cycles wide. FRAME_DONE pulses once. BUSY is 0 in the FRAME_DONE cycle.
3. **Slow buffer.** BUFFER_BUSY is delayed 5 cycles after SET_BUFFER → SET_BUFFER holds 6 cycles and ROW_DATA is unchanged throughout. No second capture occurs.
4. **Ignored start.** READ_START is pulsed during SELECT, HANDOFF and DRAIN of row 1 → the frame still ends after row 3 with exactly one FRAME_DONE, and no extra frame follows.
5. **Reset mid-frame.** RESET_N low during DRAIN of row 2 → all outputs 0 at the next edge and no FRAME_DONE. A following READ_START restarts at ROW_INDEX=0.
6. **Back-to-back frames.** READ_START is held high continuously → the second frame's ROW_SELECT=0001 appears the cycle after FRAME_DONE. Run with SETTLE_CYCLES=1 as well: SELECT lasts 1 cycle.

Source files
------------

// File: rtl/row_readout_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : row_readout_sequencer_if
//  Description : Groups the sensor-side and buffer-side signals of the row
//                readout sequencer. Modport slave is the sequencer; modport
//                master is whatever drives the column bus, the start request
//                and the buffer's busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface row_readout_sequencer_if #(
    parameter int PIXEL_ARRAY_WIDTH  = 8,
    parameter int PIXEL_ARRAY_HEIGHT = 4,
    parameter int PIXEL_BITS         = 8
);
    localparam int c_DATA_W = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int c_IDX_W  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

    logic                          READ_START;
    logic [c_DATA_W-1:0]           PIXEL_DATA_IN;
    logic                          BUFFER_BUSY;
    logic [PIXEL_ARRAY_HEIGHT-1:0] ROW_SELECT;
    logic [c_IDX_W-1:0]            ROW_INDEX;
    logic [c_DATA_W-1:0]           ROW_DATA;
    logic                          SET_BUFFER;
    logic                          BUSY;
    logic                          FRAME_DONE;

    modport slave (
        input  READ_START, PIXEL_DATA_IN, BUFFER_BUSY,
        output ROW_SELECT, ROW_INDEX, ROW_DATA, SET_BUFFER, BUSY, FRAME_DONE
    );

    modport master (
        output READ_START, PIXEL_DATA_IN, BUFFER_BUSY,
        input  ROW_SELECT, ROW_INDEX, ROW_DATA, SET_BUFFER, BUSY, FRAME_DONE
    );
endinterface
`default_nettype wire

// File: rtl/row_readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : row_readout_sequencer
//  Description : Walks the pixel array one row at a time: selects a row,
//                waits for the column bus to settle, latches it, hands it to
//                the output buffer and waits for the buffer to drain. One
//                pass over every row is a frame, closed by a FRAME_DONE pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_readout_sequencer #(
    parameter int PIXEL_ARRAY_WIDTH  = 8,
    parameter int PIXEL_ARRAY_HEIGHT = 4,
    parameter int PIXEL_BITS         = 8,
    parameter int SETTLE_CYCLES      = 2
) (
    input wire                         CLK,
    input wire                         RESET_N,
    row_readout_sequencer_if.slave     bus
);
    localparam int c_DATA_W = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int c_IDX_W  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    // Counter must hold SETTLE_CYCLES itself (it keeps counting on the capture cycle).
    localparam int c_CNT_W  = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_IDX_W-1:0]            c_LAST_ROW    = c_IDX_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [c_CNT_W-1:0]            c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PIXEL_ARRAY_HEIGHT-1:0] c_ROW0        = PIXEL_ARRAY_HEIGHT'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SELECT  = 2'd1,
        S_HANDOFF = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t                        r_state,      w_state_nx;
    logic [c_CNT_W-1:0]            r_settle_cnt, w_settle_cnt_nx;
    logic [c_IDX_W-1:0]            r_row_index,  w_row_index_nx;
    logic [PIXEL_ARRAY_HEIGHT-1:0] r_row_select, w_row_select_nx;
    logic [c_DATA_W-1:0]           r_row_data,   w_row_data_nx;
    logic                          r_set_buffer, w_set_buffer_nx;
    logic                          r_busy,       w_busy_nx;
    logic                          r_frame_done, w_frame_done_nx;

    // State and every output register; reset clears all of them.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_row_index  <= '0;
            r_row_select <= '0;
            r_row_data   <= '0;
            r_set_buffer <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_settle_cnt <= w_settle_cnt_nx;
            r_row_index  <= w_row_index_nx;
            r_row_select <= w_row_select_nx;
            r_row_data   <= w_row_data_nx;
            r_set_buffer <= w_set_buffer_nx;
            r_busy       <= w_busy_nx;
            r_frame_done <= w_frame_done_nx;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every port comes straight from a flop.
    always_comb begin
        w_state_nx      = r_state;
        w_settle_cnt_nx = r_settle_cnt;
        w_row_index_nx  = r_row_index;
        w_row_select_nx = r_row_select;
        w_row_data_nx   = r_row_data;
        w_set_buffer_nx = r_set_buffer;
        w_frame_done_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_row_select_nx = '0;
                w_set_buffer_nx = 1'b0;
                if (bus.READ_START) begin
                    w_state_nx      = S_SELECT;
                    w_row_index_nx  = '0;
                    w_settle_cnt_nx = '0;
                    w_row_select_nx = c_ROW0;
                end
            end
            S_SELECT: begin
                w_settle_cnt_nx = r_settle_cnt + 1'b1;
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    // Bus has settled: latch the row and release the select.
                    w_row_data_nx   = bus.PIXEL_DATA_IN;
                    w_row_select_nx = '0;
                    w_set_buffer_nx = 1'b1;
                    w_state_nx      = S_HANDOFF;
                end else begin
                    w_row_select_nx = c_ROW0 << r_row_index;
                end
            end
            S_HANDOFF: begin
                w_set_buffer_nx = 1'b1;
                // A busy flag left over from the previous row also counts as
                // acknowledge; the buffer's own input gating handles that case.
                if (bus.BUFFER_BUSY) begin
                    w_set_buffer_nx = 1'b0;
                    w_state_nx      = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.BUFFER_BUSY) begin
                    if (r_row_index == c_LAST_ROW) begin
                        w_state_nx      = S_IDLE;
                        w_frame_done_nx = 1'b1;
                    end else begin
                        w_row_index_nx  = r_row_index + 1'b1;
                        w_settle_cnt_nx = '0;
                        w_row_select_nx = c_ROW0 << (r_row_index + 1'b1);
                        w_state_nx      = S_SELECT;
                    end
                end
            end
            default: begin
                w_state_nx      = S_IDLE;
                w_row_select_nx = '0;
                w_set_buffer_nx = 1'b0;
            end
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    assign bus.ROW_SELECT = r_row_select;
    assign bus.ROW_INDEX  = r_row_index;
    assign bus.ROW_DATA   = r_row_data;
    assign bus.SET_BUFFER = r_set_buffer;
    assign bus.BUSY       = r_busy;
    assign bus.FRAME_DONE = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_row_readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_row_readout_sequencer
//  Description : Directed bench for row_readout_sequencer. Instance 0 uses
//                SETTLE_CYCLES=2, instance 1 uses SETTLE_CYCLES=1. A pixel
//                array model drives the column bus from ROW_SELECT and a
//                buffer model answers SET_BUFFER with BUFFER_BUSY.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_row_readout_sequencer;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int B  = 8;
    localparam int DW = W * B;

    logic clk = 1'b0;
    logic rst_n0, rst_n1, rs0, rs1, bb;
    int   sel_dut   = 0;
    int   bm_delay  = 1;
    bit   bm_en     = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    row_readout_sequencer_if #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H), .PIXEL_BITS(B)) if0 ();
    row_readout_sequencer_if #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H), .PIXEL_BITS(B)) if1 ();

    // Row r of the array drives every pixel as 8'hA0+r; nothing selected gives 8'h5A.
    function automatic logic [DW-1:0] row_pat(input int r);
        logic [7:0] b;
        b = 8'hA0 + r[7:0];
        return {W{b}};
    endfunction

    function automatic logic [DW-1:0] bus_of(input logic [H-1:0] s);
        logic [DW-1:0] v;
        logic [H-1:0]  one;
        v   = {W{8'h5A}};
        one = H'(1);
        for (int i = 0; i < H; i++)
            if (s == (one << i)) v = row_pat(i);
        return v;
    endfunction

    assign if0.READ_START    = rs0;
    assign if0.BUFFER_BUSY   = bb;
    assign if0.PIXEL_DATA_IN = bus_of(if0.ROW_SELECT);
    assign if1.READ_START    = rs1;
    assign if1.BUFFER_BUSY   = bb;
    assign if1.PIXEL_DATA_IN = bus_of(if1.ROW_SELECT);

    row_readout_sequencer #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H), .PIXEL_BITS(B),
                            .SETTLE_CYCLES(2)) dut0 (
        .CLK(clk), .RESET_N(rst_n0), .bus(if0.slave));
    row_readout_sequencer #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H), .PIXEL_BITS(B),
                            .SETTLE_CYCLES(1)) dut1 (
        .CLK(clk), .RESET_N(rst_n1), .bus(if1.slave));

    // Buffer model: BUFFER_BUSY rises bm_delay cycles after SET_BUFFER, stays 4 cycles.
    initial begin : buffer_model
        int  wait_cnt;
        int  busy_cnt;
        bit  waiting;
        logic cur_set;
        wait_cnt = 0; busy_cnt = 0; waiting = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cur_set = (sel_dut == 1) ? if1.SET_BUFFER : if0.SET_BUFFER;
            if (!bm_en) begin
                waiting  = 1'b0;
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) bb = 1'b0;
            end else if (waiting) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    waiting  = 1'b0;
                    bb       = 1'b1;
                    busy_cnt = 4;
                end
            end else if (cur_set === 1'b1) begin
                waiting  = 1'b1;
                wait_cnt = bm_delay;
            end
        end
    end

    // Waits (bounded) for FRAME_DONE on instance 0; ok=0 if it never came.
    task automatic wait_done0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (if0.FRAME_DONE === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [DW+H+2+3-1:0] all0, all1;
        rst_n0 = 1'b0; rst_n1 = 1'b0; rs0 = 1'b1; rs1 = 1'b1; bb = 1'b1; bm_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            all0 = {if0.ROW_SELECT, if0.ROW_INDEX, if0.ROW_DATA, if0.SET_BUFFER, if0.BUSY, if0.FRAME_DONE};
            n_tests++;
            if (all0 !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, all0);
            end
        end
        all1 = {if1.ROW_SELECT, if1.ROW_INDEX, if1.ROW_DATA, if1.SET_BUFFER, if1.BUSY, if1.FRAME_DONE};
        n_tests++;
        if (all1 !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_settle1: got %h expected 0", all1);
        end
        rst_n0 = 1'b1; rst_n1 = 1'b1; rs0 = 1'b0; rs1 = 1'b0; bb = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            all0 = {if0.ROW_SELECT, if0.ROW_INDEX, if0.ROW_DATA, if0.SET_BUFFER, if0.BUSY, if0.FRAME_DONE};
            n_tests++;
            if (all0 !== '0) begin
                n_fail++;
                $display("FAIL post_reset_idle cycle %0d: got %h expected 0", c, all0);
            end
        end
        bm_en = 1'b1;
    endtask

    task automatic test_full_frame;
        logic [H-1:0]  order[$];
        logic [DW-1:0] caps[$];
        int            idxs[$];
        int            sel_cyc[H];
        int            sb_high, fd_cnt, fd_k;
        logic          prev_sb, fd_busy;
        sel_dut = 0; bm_delay = 1;
        sb_high = 0; fd_cnt = 0; fd_k = -1; prev_sb = 1'b0; fd_busy = 1'bx;
        for (int i = 0; i < H; i++) sel_cyc[i] = 0;
        rs0 = 1'b1; @(negedge clk); rs0 = 1'b0;
        n_tests++;
        if (if0.BUSY !== 1'b1 || if0.ROW_SELECT !== 4'b0001) begin
            n_fail++;
            $display("FAIL start_latency: busy=%b sel=%b expected busy=1 sel=0001", if0.BUSY, if0.ROW_SELECT);
        end
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < H; i++)
                if (if0.ROW_SELECT == (4'b0001 << i)) sel_cyc[i]++;
            if (if0.ROW_SELECT != 0 && (order.size() == 0 || order[$] != if0.ROW_SELECT))
                order.push_back(if0.ROW_SELECT);
            if (if0.SET_BUFFER) begin
                sb_high++;
                if (!prev_sb) begin caps.push_back(if0.ROW_DATA); idxs.push_back(int'(if0.ROW_INDEX)); end
            end
            prev_sb = if0.SET_BUFFER;
            if (if0.FRAME_DONE) begin fd_cnt++; fd_k = k; fd_busy = if0.BUSY; end
            @(negedge clk);
        end
        n_tests++;
        if (order.size() != 4) begin
            n_fail++;
            $display("FAIL select_count: got %0d distinct selects expected 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (order[i] !== (4'b0001 << i)) begin
                    n_fail++;
                    $display("FAIL select_order[%0d]: got %b expected %b", i, order[i], 4'b0001 << i);
                end
            end
        end
        for (int i = 0; i < H; i++) begin
            n_tests++;
            if (sel_cyc[i] != 2) begin
                n_fail++;
                $display("FAIL select_width row %0d: got %0d expected 2", i, sel_cyc[i]);
            end
        end
        n_tests++;
        if (caps.size() != 4 || sb_high != 8) begin
            n_fail++;
            $display("FAIL set_buffer_pulses: got %0d pulses %0d cycles expected 4 pulses 8 cycles", caps.size(), sb_high);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (caps[i] !== row_pat(i) || idxs[i] != i) begin
                    n_fail++;
                    $display("FAIL row_data[%0d]: got %h idx %0d expected %h idx %0d", i, caps[i], idxs[i], row_pat(i), i);
                end
            end
        end
        n_tests++;
        if (fd_cnt != 1 || fd_k != 32 || fd_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_done: got count %0d at k=%0d busy=%b expected count 1 at k=32 busy=0", fd_cnt, fd_k, fd_busy);
        end
    endtask

    task automatic test_slow_buffer;
        int            widths[$];
        int            w, unstable, changes, fd_k;
        logic [DW-1:0] hold, prev_data;
        sel_dut = 0; bm_delay = 5;
        w = 0; unstable = 0; changes = 0; fd_k = -1; hold = '0;
        rs0 = 1'b1; @(negedge clk); rs0 = 1'b0;
        prev_data = if0.ROW_DATA;
        for (int k = 0; k < 60; k++) begin
            if (if0.SET_BUFFER) begin
                if (w == 0) hold = if0.ROW_DATA;
                w++;
            end else if (w != 0) begin
                widths.push_back(w);
                w = 0;
            end
            if ((if0.SET_BUFFER || bb) && if0.ROW_DATA !== hold) unstable++;
            if (k > 0 && if0.ROW_DATA !== prev_data) changes++;
            prev_data = if0.ROW_DATA;
            if (if0.FRAME_DONE) fd_k = k;
            @(negedge clk);
        end
        n_tests++;
        if (widths.size() != 4) begin
            n_fail++;
            $display("FAIL slow_pulse_count: got %0d expected 4", widths.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (widths[i] != 6) begin
                    n_fail++;
                    $display("FAIL slow_set_buffer_width[%0d]: got %0d expected 6", i, widths[i]);
                end
            end
        end
        n_tests++;
        if (unstable != 0 || changes != 4) begin
            n_fail++;
            $display("FAIL slow_row_data_hold: got %0d unstable %0d changes expected 0 and 4", unstable, changes);
        end
        n_tests++;
        if (fd_k != 48) begin
            n_fail++;
            $display("FAIL slow_frame_done_cycle: got %0d expected 48", fd_k);
        end
        bm_delay = 1;
    endtask

    task automatic test_ignored_start;
        int fd_cnt, fd_k, busy_after;
        sel_dut = 0; bm_delay = 1;
        fd_cnt = 0; fd_k = -1; busy_after = 0;
        rs0 = 1'b1; @(negedge clk); rs0 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k == 8) begin
                n_tests++;
                if (if0.ROW_SELECT !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL ignored_in_select: got sel %b expected 0010", if0.ROW_SELECT);
                end
            end
            if (k == 13) begin
                n_tests++;
                if (if0.ROW_INDEX !== 2'd1 || if0.SET_BUFFER !== 1'b0 || if0.BUSY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ignored_in_drain: got idx %0d sb %b busy %b expected 1 0 1", if0.ROW_INDEX, if0.SET_BUFFER, if0.BUSY);
                end
            end
            if (if0.FRAME_DONE) begin fd_cnt++; fd_k = k; end
            if (k > 32 && if0.BUSY) busy_after++;
            rs0 = (k == 8 || k == 10 || k == 13);
            @(negedge clk);
        end
        rs0 = 1'b0;
        n_tests++;
        if (fd_cnt != 1 || fd_k != 32 || busy_after != 0) begin
            n_fail++;
            $display("FAIL ignored_start: got done %0d at k=%0d busy_after %0d expected 1 at k=32 busy_after 0", fd_cnt, fd_k, busy_after);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [DW+H+2+3-1:0] all0;
        int                  stray;
        bit                  ok;
        sel_dut = 0; bm_delay = 1; stray = 0;
        rs0 = 1'b1; @(negedge clk); rs0 = 1'b0;
        repeat (21) @(negedge clk);
        n_tests++;
        if (if0.ROW_INDEX !== 2'd2 || if0.SET_BUFFER !== 1'b0 || if0.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_position: got idx %0d sb %b busy %b expected 2 0 1", if0.ROW_INDEX, if0.SET_BUFFER, if0.BUSY);
        end
        rst_n0 = 1'b0;
        @(negedge clk);
        rst_n0 = 1'b1;
        all0 = {if0.ROW_SELECT, if0.ROW_INDEX, if0.ROW_DATA, if0.SET_BUFFER, if0.BUSY, if0.FRAME_DONE};
        n_tests++;
        if (all0 !== '0) begin
            n_fail++;
            $display("FAIL mid_frame_reset: got %h expected 0", all0);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if0.FRAME_DONE || if0.BUSY) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL no_done_after_reset: got %0d active cycles expected 0", stray);
        end
        rs0 = 1'b1; @(negedge clk); rs0 = 1'b0;
        n_tests++;
        if (if0.ROW_INDEX !== 2'd0 || if0.ROW_SELECT !== 4'b0001 || if0.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_after_reset: got idx %0d sel %b busy %b expected 0 0001 1", if0.ROW_INDEX, if0.ROW_SELECT, if0.BUSY);
        end
        wait_done0(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL restart_frame_done: got timeout expected FRAME_DONE");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit ok;
        sel_dut = 0; bm_delay = 1;
        rs0 = 1'b1;
        @(negedge clk);
        repeat (32) @(negedge clk);
        n_tests++;
        if (if0.FRAME_DONE !== 1'b1 || if0.BUSY !== 1'b0 || if0.ROW_SELECT !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_done_cycle: got done %b busy %b sel %b expected 1 0 0000", if0.FRAME_DONE, if0.BUSY, if0.ROW_SELECT);
        end
        @(negedge clk);
        rs0 = 1'b0;
        n_tests++;
        if (if0.ROW_SELECT !== 4'b0001 || if0.ROW_INDEX !== 2'd0 || if0.BUSY !== 1'b1 || if0.FRAME_DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: got sel %b idx %0d busy %b done %b expected 0001 0 1 0", if0.ROW_SELECT, if0.ROW_INDEX, if0.BUSY, if0.FRAME_DONE);
        end
        wait_done0(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_second_frame: got timeout expected FRAME_DONE");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_settle_one;
        logic [H-1:0]  sel_at[30];
        logic          sb_at[30];
        logic          fd_at[30];
        logic          busy_at[30];
        logic [DW-1:0] data_at[30];
        int            sel_cycles;
        sel_dut = 1; bm_delay = 1; sel_cycles = 0;
        rs1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            sel_at[k] = if1.ROW_SELECT; sb_at[k] = if1.SET_BUFFER; fd_at[k] = if1.FRAME_DONE;
            busy_at[k] = if1.BUSY; data_at[k] = if1.ROW_DATA;
            if (k <= 28 && if1.ROW_SELECT != 0) sel_cycles++;
            if (k == 29) rs1 = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (sel_at[0] !== 4'b0001 || sel_at[1] !== 4'b0000 || sb_at[1] !== 1'b1 || data_at[1] !== row_pat(0)) begin
            n_fail++;
            $display("FAIL s1_first_capture: got sel %b/%b sb %b data %h expected 0001/0000 1 %h", sel_at[0], sel_at[1], sb_at[1], data_at[1], row_pat(0));
        end
        n_tests++;
        if (sel_at[7] !== 4'b0010 || sel_at[14] !== 4'b0100 || sel_at[21] !== 4'b1000 || sel_cycles != 4) begin
            n_fail++;
            $display("FAIL s1_row_steps: got %b %b %b width-sum %0d expected 0010 0100 1000 4", sel_at[7], sel_at[14], sel_at[21], sel_cycles);
        end
        n_tests++;
        if (data_at[22] !== row_pat(3)) begin
            n_fail++;
            $display("FAIL s1_last_capture: got %h expected %h", data_at[22], row_pat(3));
        end
        n_tests++;
        if (fd_at[28] !== 1'b1 || busy_at[28] !== 1'b0 || fd_at[27] !== 1'b0 || sel_at[29] !== 4'b0001) begin
            n_fail++;
            $display("FAIL s1_done_and_restart: got done %b busy %b pre %b next sel %b expected 1 0 0 0001", fd_at[28], busy_at[28], fd_at[27], sel_at[29]);
        end
        // Let the restarted frame run to completion before leaving.
        repeat (40) @(negedge clk);
        n_tests++;
        if (if1.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL s1_second_frame_end: got busy %b expected 0", if1.BUSY);
        end
        sel_dut = 0;
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0; bb = 1'b0;
        test_reset;
        test_full_frame;
        test_slow_buffer;
        test_ignored_start;
        test_reset_mid_frame;
        test_back_to_back;
        test_settle_one;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
